genesis_pad_scanner: RTL and testbench



---
 rtl/genesis_pad_scanner.sv | 230 +++++++++++++++++++++++
 tb/tb_genesis_pad_scanner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/genesis_pad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : genesis_pad_scanner                                        |
// | Description : Frame-triggered Mega Drive/Genesis 3/6-button pad scanner. |
// |               Drives the pad select line through a fixed toggle          |
// |               sequence, samples the multiplexed pins and commits a       |
// |               12-bit pressed-button word once per enable rising edge.    |
// | Config      : PAD_SIX_BUTTON_EN - defined: 8-phase sequence with X/Y/Z/  |
// |               Mode and six-button detection; undefined: 2-phase 3-button |
// |               scan, btn_out[11:8] and six_button tied to 0.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module genesis_pad_scanner #(
   parameter int PHASE_CYCLES    = 1000,
   parameter int COOLDOWN_CYCLES = 200000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        pin_1,
   input  logic        pin_2,
   input  logic        pin_3,
   input  logic        pin_4,
   input  logic        pin_6,
   input  logic        pin_9,
   output logic        select,
   output logic [11:0] btn_out,
   output logic        btn_valid,
   output logic        pad_present,
   output logic        six_button,
   output logic        busy
);

`ifdef PAD_SIX_BUTTON_EN
   localparam int c_num_phases = 8;
`else
   localparam int c_num_phases = 2;
`endif
   // One counter serves both the select phases and the cooldown interval.
   localparam int c_cnt_max = (PHASE_CYCLES > COOLDOWN_CYCLES) ? PHASE_CYCLES : COOLDOWN_CYCLES;
   localparam int c_cnt_w   = $clog2(c_cnt_max);
   localparam logic [c_cnt_w-1:0] c_phase_last = c_cnt_w'(PHASE_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_cool_last  = c_cnt_w'(COOLDOWN_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
   localparam logic [2:0]         c_last_phase = 3'(c_num_phases - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_SCAN     = 2'd1,
      S_COMMIT   = 2'd2,
      S_COOLDOWN = 2'd3
   } state_t;

   state_t               r_state, w_state_next;
   logic [c_cnt_w-1:0]   r_cnt, w_cnt_next;
   logic [2:0]           r_phase, w_phase_next;
   logic                 r_enable_q;
   logic [5:0]           r_sync1, r_sync2;
   logic [5:0]           w_pins, w_act;
   logic                 w_start, w_sample, w_commit;
   logic [7:0]           r_sh_base, w_sh_base_next;
   logic                 r_sh_present, w_sh_present_next;
   logic [7:0]           r_btn_base;
`ifdef PAD_SIX_BUTTON_EN
   logic [3:0]           r_sh_ext, w_sh_ext_next;   // [0]X [1]Y [2]Z [3]Mode
   logic                 r_sh_six, w_sh_six_next;
   logic [3:0]           r_btn_ext;
   logic                 r_six;
`endif

   // Pin vector order {9,6,4,3,2,1}; w_act is 1 where a pin is pulled low.
   assign w_pins  = {pin_9, pin_6, pin_4, pin_3, pin_2, pin_1};
   assign w_act   = ~r_sync2;
   assign w_start = enable & ~r_enable_q & (r_state == S_IDLE);
   assign busy    = (r_state != S_IDLE);

`ifdef PAD_SIX_BUTTON_EN
   assign btn_out    = {r_btn_ext, r_btn_base};
   assign six_button = r_six;
`else
   assign btn_out    = {4'b0000, r_btn_base};
   assign six_button = 1'b0;
`endif

   // Two-flop synchronisers on the asynchronous pad pins plus the enable history flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1    <= '1;
         r_sync2    <= '1;
         r_enable_q <= 1'b0;
      end else begin
         r_sync1    <= w_pins;
         r_sync2    <= r_sync1;
         r_enable_q <= enable;
      end
   end

   // FSM state, phase and shared counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_phase <= 3'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_phase <= w_phase_next;
      end
   end

   // Next-state logic: phase sequencing, sample strobe on each phase's final cycle, commit after the last phase.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_phase_next = r_phase;
      w_sample     = 1'b0;
      w_commit     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_state_next = S_SCAN;
               w_cnt_next   = '0;
               w_phase_next = 3'd0;
            end
         end
         S_SCAN: begin
            if (r_cnt == c_phase_last) begin
               w_sample   = 1'b1;
               w_cnt_next = '0;
               if (r_phase == c_last_phase) begin
                  w_commit     = 1'b1;
                  w_state_next = S_COMMIT;
               end else begin
                  w_phase_next = r_phase + 3'd1;
               end
            end else begin
               w_cnt_next = r_cnt + c_cnt_one;
            end
         end
         S_COMMIT: begin
            w_state_next = S_COOLDOWN;
            w_cnt_next   = '0;
         end
         S_COOLDOWN: begin
            if (r_cnt == c_cool_last) begin
               w_state_next = S_IDLE;
            end else begin
               w_cnt_next = r_cnt + c_cnt_one;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Shadow update: decode the synchronised pins according to the phase just completed.
   always_comb begin
      w_sh_base_next    = r_sh_base;
      w_sh_present_next = r_sh_present;
`ifdef PAD_SIX_BUTTON_EN
      w_sh_ext_next     = r_sh_ext;
      w_sh_six_next     = r_sh_six;
`endif
      if (w_sample) begin
         case (r_phase)
            3'd0: begin
               w_sh_present_next = w_act[2] & w_act[3];
               w_sh_base_next[4] = w_act[4];   // A
               w_sh_base_next[7] = w_act[5];   // Start
            end
            3'd1: begin
               w_sh_base_next[3:0] = w_act[3:0]; // Up/Down/Left/Right
               w_sh_base_next[5]   = w_act[4];   // B
               w_sh_base_next[6]   = w_act[5];   // C
            end
`ifdef PAD_SIX_BUTTON_EN
            3'd4: begin
               w_sh_six_next = r_sh_present & (&w_act[3:0]);
            end
            3'd5: begin
               if (r_sh_six) begin
                  w_sh_ext_next[2] = w_act[0];   // Z
                  w_sh_ext_next[1] = w_act[1];   // Y
                  w_sh_ext_next[0] = w_act[2];   // X
                  w_sh_ext_next[3] = w_act[3];   // Mode
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // Shadow registers, registered select line and the commit of results to the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sh_base    <= 8'h00;
         r_sh_present <= 1'b0;
         r_btn_base   <= 8'h00;
         pad_present  <= 1'b0;
         btn_valid    <= 1'b0;
         select       <= 1'b1;
`ifdef PAD_SIX_BUTTON_EN
         r_sh_ext     <= 4'h0;
         r_sh_six     <= 1'b0;
         r_btn_ext    <= 4'h0;
         r_six        <= 1'b0;
`endif
      end else begin
         r_sh_base    <= w_sh_base_next;
         r_sh_present <= w_sh_present_next;
         btn_valid    <= w_commit;
         // Select is low in even phases, high in odd phases and outside SCAN.
         select       <= (w_state_next == S_SCAN) ? w_phase_next[0] : 1'b1;
`ifdef PAD_SIX_BUTTON_EN
         r_sh_ext     <= w_sh_ext_next;
         r_sh_six     <= w_sh_six_next;
`endif
         if (w_commit) begin
            pad_present <= w_sh_present_next;
            r_btn_base  <= w_sh_present_next ? w_sh_base_next : 8'h00;
`ifdef PAD_SIX_BUTTON_EN
            r_six       <= w_sh_present_next & w_sh_six_next;
            r_btn_ext   <= (w_sh_present_next & w_sh_six_next) ? w_sh_ext_next : 4'h0;
`endif
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_genesis_pad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_genesis_pad_scanner                                     |
// | Description : Self-checking bench for genesis_pad_scanner with a         |
// |               behavioural 3/6-button pad model and scan reference model. |
// | Config      : PAD_SIX_BUTTON_EN selects the 8-phase expectations.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_genesis_pad_scanner;
   localparam int P = 4;
   localparam int C = 16;
`ifdef PAD_SIX_BUTTON_EN
   localparam int NPH = 8;
`else
   localparam int NPH = 2;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        pin_1, pin_2, pin_3, pin_4, pin_6, pin_9;
   logic        select, btn_valid, pad_present, six_button, busy;
   logic [11:0] btn_out;

   int          checks = 0;
   int          errors = 0;

   // Pad model state: kind 0 = unplugged, 1 = 3-button, 2 = 6-button.
   int          pad_kind = 0;
   logic [11:0] pad_btn  = 12'h000;
   int          lows     = 0;   // select falling edges since the pad's counter reset
   int          hi_run   = 0;   // consecutive clocks with select high
   logic        prev_sel = 1'b1;

   typedef struct {
      int          kind;
      logic [11:0] btn;
      logic [11:0] exp_btn;
      logic        exp_pres;
      logic        exp_six;
   } vec_t;
   vec_t tbl [6];

   genesis_pad_scanner #(.PHASE_CYCLES(P), .COOLDOWN_CYCLES(C)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .pin_1(pin_1), .pin_2(pin_2), .pin_3(pin_3), .pin_4(pin_4),
      .pin_6(pin_6), .pin_9(pin_9),
      .select(select), .btn_out(btn_out), .btn_valid(btn_valid),
      .pad_present(pad_present), .six_button(six_button), .busy(busy)
   );

   always #5 clk = ~clk;

   // Pad pins {9,6,4,3,2,1}, active low, for a select level and low-pulse number.
   function automatic logic [5:0] pad_pins(input logic sel, input int n, input int kind,
                                           input logic [11:0] b);
      logic [5:0] pressed;
      if (kind == 0) return 6'h3f;
      if (sel) begin
         if (kind == 2 && n == 3) pressed = {b[6], b[5], b[11], b[8], b[9], b[10]};
         else                     pressed = {b[6], b[5], b[3], b[2], b[1], b[0]};
      end else begin
         if (kind == 2 && n == 3)      pressed = {b[7], b[4], 4'b1111};
         else if (kind == 2 && n == 4) pressed = {b[7], b[4], 4'b0000};
         else                          pressed = {b[7], b[4], 2'b11, b[1], b[0]};
      end
      return ~pressed;
   endfunction

   // Reference: walk the phases, apply the sampling rules, then the commit masking.
   function automatic logic [13:0] ref_scan(input int kind, input logic [11:0] b);
      logic [11:0] r;
      logic        pres, six;
      logic [5:0]  pn;
      r = 12'h000; pres = 1'b0; six = 1'b0;
      for (int k = 0; k < NPH; k++) begin
         pn = pad_pins(k % 2 == 1, k / 2 + 1, kind, b);
         case (k)
            0: begin pres = !pn[2] && !pn[3]; r[4] = !pn[4]; r[7] = !pn[5]; end
            1: begin r[3:0] = ~pn[3:0]; r[5] = !pn[4]; r[6] = !pn[5]; end
            4: six = pres && (pn[3:0] == 4'b0000);
            5: if (six) begin r[10] = !pn[0]; r[9] = !pn[1]; r[8] = !pn[2]; r[11] = !pn[3]; end
            default: ;
         endcase
      end
      if (!six) r[11:8] = 4'h0;
      if (!pres) begin r = 12'h000; six = 1'b0; end
      return {pres, six, r};
   endfunction

   assign {pin_9, pin_6, pin_4, pin_3, pin_2, pin_1} = pad_pins(select, lows, pad_kind, pad_btn);

   // Pad counter: counts select low pulses, resets after a long select-high period.
   always @(posedge clk) begin
      #1;
      if (prev_sel === 1'b1 && select === 1'b0) lows = lows + 1;
      if (select === 1'b1) hi_run = hi_run + 1;
      else                 hi_run = 0;
      if (hi_run > 10) lows = 0;
      prev_sel = select;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic wait_pad_idle();
      int t = 0;
      while (!(busy === 1'b0 && hi_run > 12) && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("pad_idle_reached", 32'(t < 400), 1);
   endtask

   // One full scan with enable held high through commit; checks waveform, commit and cooldown.
   task automatic do_scan(input int kind, input logic [11:0] b, input logic [11:0] eb,
                          input logic ep, input logic es, input string tag);
      logic wave_ok = 1'b1;
      logic cool_ok = 1'b1;
      pad_kind = kind;
      pad_btn  = b;
      wait_pad_idle();
      @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      check({tag, " start_select_low"}, 32'(select), 0);
      for (int k = 0; k < NPH * P; k++) begin
         if (select !== 1'((k / P) % 2)) wave_ok = 1'b0;
         if (btn_valid !== 1'b0 || busy !== 1'b1) wave_ok = 1'b0;
         @(negedge clk);
      end
      check({tag, " select_wave"}, 32'(wave_ok), 1);
      check({tag, " valid_at_commit"}, 32'(btn_valid), 1);
      check({tag, " btn_out"}, 32'(btn_out), 32'(eb));
      check({tag, " pad_present"}, 32'(pad_present), 32'(ep));
      check({tag, " six_button"}, 32'(six_button), 32'(es));
      @(negedge clk);
      check({tag, " valid_one_cycle"}, 32'(btn_valid), 0);
      enable = 1'b0;
      for (int k = 0; k < C; k++) begin
         if (busy !== 1'b1 || select !== 1'b1) cool_ok = 1'b0;
         @(negedge clk);
      end
      check({tag, " cooldown"}, 32'(cool_ok), 1);
      check({tag, " idle_after_cooldown"}, 32'(busy), 0);
      check({tag, " btn_hold"}, 32'(btn_out), 32'(eb));
   endtask

   task automatic seq_ignored_edges();
      int valids    = 0;
      int commit_at = -1;
      pad_kind = 1;
      pad_btn  = 12'h011;
      wait_pad_idle();
      @(negedge clk);
      enable = 1'b1;
      for (int k = 0; k < 2 * (NPH * P + C) + 20; k++) begin
         @(negedge clk);
         if (btn_valid === 1'b1) begin valids++; commit_at = k; end
         if (k == P + 1)         enable = 1'b0;
         if (k == P + 2)         enable = 1'b1;   // edge during SCAN
         if (k == NPH * P + 4)   enable = 1'b0;
         if (k == NPH * P + 5)   enable = 1'b1;   // edge during COOLDOWN
      end
      check("ignored_edges valid_count", 32'(valids), 1);
      check("ignored_edges commit_cycle", 32'(commit_at), 32'(NPH * P));
      check("ignored_edges btn_out", 32'(btn_out), 32'h011);
      enable = 1'b0;
   endtask

   task automatic seq_reset_abort();
      int   ab = (NPH == 8) ? 3 : 1;
      logic ok = 1'b1;
      pad_kind = 1;
      pad_btn  = 12'h011;
      wait_pad_idle();
      @(negedge clk);
      enable = 1'b1;
      for (int k = 0; k < ab * P + 2; k++) @(negedge clk);
      rst    = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      check("abort select", 32'(select), 1);
      check("abort busy", 32'(busy), 0);
      check("abort btn_valid", 32'(btn_valid), 0);
      check("abort btn_out", 32'(btn_out), 0);
      check("abort pad_present", 32'(pad_present), 0);
      rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (btn_valid !== 1'b0 || select !== 1'b1) ok = 1'b0;
      end
      check("abort no_commit", 32'(ok), 1);
   endtask

   initial begin
      logic [13:0] r;
      int          kind;
      logic [11:0] b;
`ifdef PAD_SIX_BUTTON_EN
      tbl[0] = '{1, 12'h011, 12'h011, 1'b1, 1'b0};
      tbl[1] = '{2, 12'h980, 12'h980, 1'b1, 1'b1};
      tbl[2] = '{0, 12'hfff, 12'h000, 1'b0, 1'b0};
      tbl[3] = '{2, 12'h420, 12'h420, 1'b1, 1'b1};
      tbl[4] = '{1, 12'h0f4, 12'h0f4, 1'b1, 1'b0};
      tbl[5] = '{2, 12'hf00, 12'hf00, 1'b1, 1'b1};
`else
      tbl[0] = '{1, 12'h011, 12'h011, 1'b1, 1'b0};
      tbl[1] = '{2, 12'h980, 12'h080, 1'b1, 1'b0};
      tbl[2] = '{0, 12'hfff, 12'h000, 1'b0, 1'b0};
      tbl[3] = '{2, 12'h420, 12'h020, 1'b1, 1'b0};
      tbl[4] = '{1, 12'h0f4, 12'h0f4, 1'b1, 1'b0};
      tbl[5] = '{2, 12'hf00, 12'h000, 1'b1, 1'b0};
`endif
      rst    = 1'b1;
      enable = 1'b0;
      repeat (5) @(negedge clk);
      check("reset select", 32'(select), 1);
      rst = 1'b0;
      @(negedge clk);
      check("reset btn_out", 32'(btn_out), 0);
      check("reset busy", 32'(busy), 0);
      check("reset btn_valid", 32'(btn_valid), 0);
      check("reset pad_present", 32'(pad_present), 0);
      check("reset six_button", 32'(six_button), 0);

      for (int i = 0; i < 6; i++)
         do_scan(tbl[i].kind, tbl[i].btn, tbl[i].exp_btn, tbl[i].exp_pres, tbl[i].exp_six, "table");

      for (int i = 0; i < 12; i++) begin
         kind = int'($urandom_range(0, 2));
         b    = 12'($urandom);
         r    = ref_scan(kind, b);
         do_scan(kind, b, r[11:0], r[13], r[12], "random");
      end

      seq_ignored_edges();
      do_scan(0, 12'h000, 12'h000, 1'b0, 1'b0, "no_pad");
      seq_reset_abort();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
